seg_scan: RTL and testbench

Time-multiplexed scanner for the board's 8-digit common-anode seven-segment display. Holds a tear-free shadow copy of a 32-bit hex value, steps through the digits at a fixed refresh rate and drives the active-low anode enables. Sits directly upstream of the hex-to-segment decoder: it presents one 4-bit digit code per slot, which the decoder turns into segment drive, plus a separate active-low decimal-point signal.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/scan_tick.sv | 53 +++++
 rtl/seg_scan.sv | 135 +++++++++++++
 tb/tb_seg_scan.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and the display-set payload for the seven-segment scanner.
// Optional feature macro: SEG_SCAN_LZB_EN (adds the leading-zero mask helper).
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned VALUE_W    = NUM_DIGITS * DIGIT_W;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

  // One complete display image: hex value plus per-digit enables.
  typedef struct packed {
    logic [VALUE_W-1:0]    value;
    logic [NUM_DIGITS-1:0] dig_en;
    logic [NUM_DIGITS-1:0] dp_en;
  } disp_set_t;

`ifdef SEG_SCAN_LZB_EN
  // Bit i set when nibble i and every nibble above it are zero; digit 0 always shows.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [VALUE_W-1:0] v);
    logic [NUM_DIGITS-1:0] mask;
    mask = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      mask[IDX_W'(i)] = ((v >> (DIGIT_W * i)) == '0);
    end
    return mask;
  endfunction
`endif

endpackage

// File: rtl/scan_tick.sv
// scan_tick: slot counter and digit index for the display scan.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   idx         current digit index (0..NUM_DIGITS-1)
//   in_blank    high during the first BLANK cycles of each slot
//   frame_wrap  high in the last cycle of the last digit slot (idx wraps next edge)
// Parameters: CLK_DIV (>= 2) cycles per slot, BLANK (< CLK_DIV) dark cycles per slot.
module scan_tick
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned BLANK   = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx,
  output logic             in_blank,
  output logic             frame_wrap
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;
  logic             slot_end;
  logic             last_digit;

  assign slot_end   = (cnt == CNT_W'(CLK_DIV - 1));
  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_wrap = slot_end && last_digit;

  // Slot counter and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= last_digit ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Anti-ghosting window; a zero-length window is simply never active.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CNT_W'(BLANK));
    end
  endgenerate

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scanner for an 8-digit common-anode display.
// Holds a pending and a shadow copy of the display image; the shadow only
// changes at frame boundaries so a frame never tears.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   value        eight hex nibbles, nibble i shows on digit i (digit 0 rightmost)
//   dig_en       per-digit enable (0 = dark)
//   dp_en        per-digit decimal point enable
//   load         one-cycle strobe capturing value/dig_en/dp_en
//   code         nibble for the current digit, to the segment decoder
//   an           active-low anode enables, at most one bit low
//   dp_n         active-low decimal point
//   frame_done   one-cycle pulse aligned with the first output cycle of digit 0
// Parameters: CLK_DIV (>= 2) cycles per slot, BLANK (< CLK_DIV) dark cycles per slot.
// Optional feature macro: SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned BLANK   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic [NUM_DIGITS-1:0] dig_en,
  input  logic [NUM_DIGITS-1:0] dp_en,
  input  logic                  load,
  output logic [DIGIT_W-1:0]    code,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp_n,
  output logic                  frame_done
);

  logic [IDX_W-1:0] idx;
  logic             in_blank;
  logic             frame_wrap;

  disp_set_t in_set;
  disp_set_t pending;
  disp_set_t shadow;
  disp_set_t shadow_src;
  logic      pend;
  logic      shadow_upd;
  logic      wrap_q;

  logic                  lit_c;
  logic                  lz_dark_c;
  logic [NUM_DIGITS-1:0] an_nx;
  logic [DIGIT_W-1:0]    code_nx;
  logic                  dp_n_nx;

  scan_tick #(
    .CLK_DIV (CLK_DIV),
    .BLANK   (BLANK)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .in_blank   (in_blank),
    .frame_wrap (frame_wrap)
  );

  assign in_set = {value, dig_en, dp_en};

  // A load in the boundary cycle bypasses the pending copy.
  assign shadow_src = load ? in_set : pending;
  assign shadow_upd = frame_wrap && (load || pend);

  // Pending and shadow image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      pend    <= 1'b0;
      shadow  <= '0;
    end else begin
      if (shadow_upd) begin
        shadow <= shadow_src;
      end
      if (frame_wrap) begin
        pend <= 1'b0;
      end else if (load) begin
        pending <= in_set;
        pend    <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lz_blank;

  // Mask computed once per shadow update, alongside the new image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lz_blank <= '0;
    end else if (shadow_upd) begin
      lz_blank <= lz_mask(shadow_src.value);
    end
  end

  assign lz_dark_c = lz_blank[idx];
`else
  assign lz_dark_c = 1'b0;
`endif

  assign lit_c = shadow.dig_en[idx] && !in_blank && !lz_dark_c;

  // Next output values; the nibble is presented even while the digit is dark.
  always_comb begin
    an_nx   = AN_OFF;
    dp_n_nx = 1'b1;
    code_nx = DIGIT_W'(shadow.value >> (DIGIT_W * idx));
    if (lit_c) begin
      an_nx   = AN_OFF ^ (NUM_DIGITS'(1) << idx);
      dp_n_nx = ~shadow.dp_en[idx];
    end
  end

  // Registered outputs; frame_done is delayed twice to line up with digit 0's first output cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= AN_OFF;
      code       <= '0;
      dp_n       <= 1'b1;
      wrap_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nx;
      code       <= code_nx;
      dp_n       <= dp_n_nx;
      wrap_q     <= frame_wrap;
      frame_done <= wrap_q;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan with CLK_DIV = 8, BLANK = 2.
// The reference model derives the expected display from the absolute cycle
// position since reset and the list of loads with the edge they were taken on.
module tb_seg_scan;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 8 * CLK_DIV;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic [7:0]  dig_en;
  logic [7:0]  dp_en;
  logic        load;
  logic [3:0]  code;
  logic [7:0]  an;
  logic        dp_n;
  logic        frame_done;

  seg_scan #(
    .CLK_DIV (CLK_DIV),
    .BLANK   (BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dig_en     (dig_en),
    .dp_en      (dp_en),
    .load       (load),
    .code       (code),
    .an         (an),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release.
  int edges;
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  int          ld_edge[$];
  logic [47:0] ld_data[$];
  int          n_pass;
  int          n_checks;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, edges);
  endtask

  // Expected outputs for the cycle showing scan position q.
  task automatic model(input int q, output logic [7:0] e_an, output logic [3:0] e_code,
                       output logic e_dp_n, output logic e_fd);
    int          f, d, c, top;
    logic [47:0] s;
    logic [31:0] v;
    logic [7:0]  de, dp;
    logic        lit;
    f = q / FRAME;
    d = (q / CLK_DIV) % 8;
    c = q % CLK_DIV;
    s = '0;
    if (f > 0) begin
      foreach (ld_edge[i]) if (ld_edge[i] <= f * FRAME) s = ld_data[i];
    end
    v  = s[47:16];
    de = s[15:8];
    dp = s[7:0];
    e_code = 4'((v >> (4 * d)) & 32'hF);
    lit = de[d] && (c >= BLANK);
`ifdef SEG_SCAN_LZB_EN
    top = 0;
    for (int k = 7; k >= 0; k--) begin
      if (top == 0 && ((v >> (4 * k)) & 32'hF) != 0) top = k;
    end
    if (d > top) lit = 1'b0;
`else
    top = 7;
`endif
    e_an   = lit ? ~(8'h01 << d) : 8'hFF;
    e_dp_n = lit ? ~dp[d] : 1'b1;
    e_fd   = (q % FRAME == 0) && (q >= FRAME);
  endtask

  task automatic check_now();
    logic [7:0] e_an;
    logic [3:0] e_code;
    logic       e_dp_n, e_fd;
    if (edges == 0) begin
      e_an = 8'hFF; e_code = 4'h0; e_dp_n = 1'b1; e_fd = 1'b0;
    end else begin
      model(edges - 1, e_an, e_code, e_dp_n, e_fd);
    end
    chk("an", 32'(an), 32'(e_an));
    chk("code", 32'(code), 32'(e_code));
    chk("dp_n", 32'(dp_n), 32'(e_dp_n));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_now();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] de, input logic [7:0] dp);
    value  = v;
    dig_en = de;
    dp_en  = dp;
    load   = 1'b1;
    ld_edge.push_back(edges + 1);
    ld_data.push_back({v, de, dp});
    step();
    load   = 1'b0;
    value  = $urandom;
    dig_en = 8'($urandom);
    dp_en  = 8'($urandom);
  endtask

  // Advance until the next rising edge is a frame boundary.
  task automatic to_boundary();
    for (int k = 0; k < FRAME && ((edges + 1) % FRAME) != 0; k++) step();
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    rst    = 1'b1;
    load   = 1'b0;
    value  = '0;
    dig_en = '0;
    dp_en  = '0;
    repeat (3) @(negedge clk);
    check_now();
    rst = 1'b0;

    // Idle: dark for three frames, frame_done every frame.
    run(3 * FRAME);

    // Basic image with a decimal point on digit 2.
    do_load(32'h1234_ABCD, 8'hFF, 8'h04);
    run(2 * FRAME);

    // Two loads inside one frame: last wins.
    run(10);
    do_load(32'h1111_1111, 8'hFF, 8'h00);
    run(7);
    do_load(32'h2222_2222, 8'hFF, 8'h80);
    run(FRAME + 20);

    // Load exactly in the boundary cycle shows in the same frame.
    to_boundary();
    do_load(32'h5A5A_9876, 8'hFF, 8'h11);
    run(FRAME);

    // Upper digits disabled.
    do_load(32'hFEDC_BA98, 8'h0F, 8'hFF);
    run(2 * FRAME);

    // Leading-zero cases.
    do_load(32'h0000_0A05, 8'hFF, 8'h00);
    run(2 * FRAME);
    do_load(32'h0000_0000, 8'hFF, 8'h01);
    run(2 * FRAME);

    // Random images at random times.
    for (int r = 0; r < 6; r++) begin
      run($urandom_range(0, 90));
      do_load($urandom, 8'($urandom), 8'($urandom));
    end
    run(2 * FRAME + 5);

    // Mid-slot reset on digit 5 with a load still pending.
    do_load(32'h7654_3210, 8'hFF, 8'hFF);
    to_boundary();
    run(3);
    do_load(32'h9999_9999, 8'hFF, 8'h00);
    for (int k = 0; k < 2 * FRAME &&
         !(((edges - 1) / CLK_DIV) % 8 == 5 && ((edges - 1) % CLK_DIV) == 4); k++) step();
    chk("an_before_rst", 32'(an), 32'(8'hDF));
    #2 rst = 1'b1;
    #1;
    chk("an_rst", 32'(an), 32'(8'hFF));
    chk("code_rst", 32'(code), 32'h0);
    chk("dp_n_rst", 32'(dp_n), 32'h1);
    chk("frame_done_rst", 32'(frame_done), 32'h0);
    ld_edge.delete();
    ld_data.delete();
    @(negedge clk);
    check_now();
    rst = 1'b0;
    run(2 * FRAME + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
